// File: rtl/mux_pkg.sv
// Shared types for the 2:1 byte mux control stage: arbiter states, data type
// and a saturating counter helper.
package mux_pkg;

  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT1 = 2'd1,
    GNT2 = 2'd2
  } arb_state_t;

  typedef logic [DEFAULT_DATA_W-1:0] mux_data_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mux_out_reg.sv
// One-entry valid/ready output register. A new byte may be loaded in the same
// cycle the held one is consumed, so back-to-back beats flow without bubbles.
module mux_out_reg
  import mux_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  input  logic              out_ready,
  output logic [DATA_W-1:0] dout,
  output logic              out_valid,
  output logic              load_en
);

  logic [DATA_W-1:0] data_reg;
  logic              valid_reg;

  assign load_en   = !valid_reg | out_ready;
  assign dout      = data_reg;
  assign out_valid = valid_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_reg  <= '0;
      valid_reg <= 1'b0;
    end else if (load) begin
      data_reg  <= din;
      valid_reg <= 1'b1;
    end else if (out_ready) begin
      valid_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter with bounded burst hold driving the 2:1 byte mux select.
// Optional per-source accept counters are built when MUX_ARB_STATS_EN is defined.
module mux_sel_arbiter
  import mux_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in1,
  input  logic              in1_valid,
  output logic              in1_ready,
  input  logic [DATA_W-1:0] in2,
  input  logic              in2_valid,
  output logic              in2_ready,
  output logic              sel,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  input  logic              out_ready
`ifdef MUX_ARB_STATS_EN
  ,
  output logic [15:0]       cnt_in1,
  output logic [15:0]       cnt_in2
`endif
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] BURST_MAX    = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] BURST_HIT_AT = CNT_W'(BURST_LEN - 1);

  arb_state_t        state_reg, state_next;
  logic [CNT_W-1:0]  burst_cnt_reg;
  logic              last_in1_reg;
  logic              load_en;
  logic              acc1, acc2, accept, burst_hit;
  logic [DATA_W-1:0] load_data;

  // Readies come from registered state and the output stage only.
  assign in1_ready = (state_reg == GNT1) & load_en;
  assign in2_ready = (state_reg == GNT2) & load_en;
  assign acc1      = in1_valid & in1_ready;
  assign acc2      = in2_valid & in2_ready;
  assign accept    = acc1 | acc2;
  assign burst_hit = accept && (burst_cnt_reg >= BURST_HIT_AT);
  assign load_data = acc1 ? in1 : in2;
  assign sel       = (state_reg == GNT1);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (in1_valid && in2_valid) state_next = last_in1_reg ? GNT2 : GNT1;
        else if (in1_valid)         state_next = GNT1;
        else if (in2_valid)         state_next = GNT2;
      end
      GNT1: begin
        if (in2_valid && (!in1_valid || burst_hit)) state_next = GNT2;
        else if (!in1_valid)                        state_next = IDLE;
      end
      GNT2: begin
        if (in1_valid && (!in2_valid || burst_hit)) state_next = GNT1;
        else if (!in2_valid)                        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      burst_cnt_reg <= '0;
      last_in1_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      // A stalled output stage never accepts, so the count holds naturally.
      if (state_next != state_reg)
        burst_cnt_reg <= '0;
      else if (accept && (burst_cnt_reg != BURST_MAX))
        burst_cnt_reg <= burst_cnt_reg + CNT_W'(1);
      if (acc1)      last_in1_reg <= 1'b1;
      else if (acc2) last_in1_reg <= 1'b0;
    end
  end

  mux_out_reg #(.DATA_W(DATA_W)) u_out (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .din       (load_data),
    .out_ready (out_ready),
    .dout      (out),
    .out_valid (out_valid),
    .load_en   (load_en)
  );

`ifdef MUX_ARB_STATS_EN
  logic [1:0] acc_vec;
  assign acc_vec = {acc2, acc1};

  for (genvar gi = 0; gi < 2; gi++) begin : g_stat
    logic [15:0] cnt_reg;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)              cnt_reg <= '0;
      else if (acc_vec[gi]) cnt_reg <= sat_inc16(cnt_reg);
    end
  end

  assign cnt_in1 = g_stat[0].cnt_reg;
  assign cnt_in2 = g_stat[1].cnt_reg;
`endif

endmodule
